// File: rtl/alu_operand_rf.sv
// Operand-issue stage: 8x16 register file, two read ports, valid/ready operand register to the ALU.
// Optional same-edge write forwarding into the reads is enabled by defining ALU_OPERAND_RF_BYPASS_EN.
module alu_operand_rf #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int AW     = 3,
    parameter int CTL_W  = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AW-1:0]     in_rs,
    input  logic [AW-1:0]     in_rt,
    input  logic [CTL_W-1:0]  in_ctl,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [CTL_W-1:0]  out_ctl
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_a_q, out_a_d;
    logic [DATA_W-1:0] out_b_q, out_b_d;
    logic [CTL_W-1:0]  out_ctl_q, out_ctl_d;

    logic              accept;
    logic [DATA_W-1:0] rd_a, rd_b;

    // Writes are independent of the handshake, so a stall never blocks them.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_wr
        assign regs_d[gi] = (wr_en && (wr_addr == AW'(gi))) ? wr_data : regs_q[gi];
    end

    always_comb begin
`ifdef ALU_OPERAND_RF_BYPASS_EN
        rd_a = (wr_en && (wr_addr == in_rs)) ? wr_data : regs_q[in_rs];
        rd_b = (wr_en && (wr_addr == in_rt)) ? wr_data : regs_q[in_rt];
`else
        rd_a = regs_q[in_rs];
        rd_b = regs_q[in_rt];
`endif
    end

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_ctl_d   = out_ctl_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_a_d     = rd_a;
            out_b_d     = rd_b;
            out_ctl_d   = in_ctl;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_ctl_q   <= '0;
        end else begin
            regs_q      <= regs_d;
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_ctl_q   <= out_ctl_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_ctl   = out_ctl_q;

endmodule
